instr_fetch_stage: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Samples the PC address, issues a req/ack read to instruction memory, and holds the returned word plus its PC in a one-entry IF/ID slot for decode (valid/ready).
- Drives the PC write-enable (`PcAdvance`) only when a fetch completes and is kept.
- Supports a flush (taken branch/jump) that discards any in-flight fetch.

---
 rtl/instr_fetch_stage_pkg.sv | 23 ++
 rtl/instr_fetch_stage_slot.sv | 46 ++++
 rtl/instr_fetch_stage.sv | 112 +++++++++++
 tb/tb_instr_fetch_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM state codes,
// default widths/timeout and the reset address.
package instr_fetch_stage_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 8;
    localparam int TIMEOUT_DEF = 15;

    localparam int RESET_ADDR = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    // Ack-wait counter width: enough for TIMEOUT, never narrower than 4 bits.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/instr_fetch_stage_slot.sv
// One-entry IF/ID register (fetch_slot): holds the fetched word and its PC,
// with valid/ready handshake, capture, flush and drain.
module fetch_slot
    import instr_fetch_stage_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               capture,
    input  logic               flush,
    input  logic               ready,
    input  logic [INSTR_W-1:0] cap_instr,
    input  logic [ADDR_W-1:0]  cap_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic               free
);

    assign free = !valid || ready;

    // NOTE: the data registers are reset as well, so Instr/InstrPC read 0 after reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else begin
            // Flush beats capture; capture beats a same-cycle drain.
            if (flush)
                valid <= 1'b0;
            else if (capture)
                valid <= 1'b1;
            else if (ready)
                valid <= 1'b0;

            if (capture && !flush) begin
                instr <= cap_instr;
                pc    <= cap_pc;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: req/ack fetch FSM feeding a one-entry IF/ID slot.
// Optional FETCH_PERF_EN adds saturating FetchCount/StallCount outputs.
module instr_fetch_stage
    import instr_fetch_stage_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [ADDR_W-1:0]  PcAddr,
    output logic               PcAdvance,
    output logic               MemReq,
    output logic [ADDR_W-1:0]  MemAddr,
    input  logic               MemAck,
    input  logic [INSTR_W-1:0] MemData,
    input  logic               Flush,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               FetchErr
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        FetchCount,
    output logic [15:0]        StallCount
`endif
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [1:0]        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              slot_free;
    logic              capture;
    logic              timed_out;

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign capture   = (state == ST_REQ) && MemAck && !Flush;
    // NOTE: MemReq is decoded from the state register, so it can never disagree with the FSM.
    assign MemReq    = (state == ST_REQ) || (state == ST_DRAIN);
    assign MemAddr   = mem_addr_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            mem_addr_q <= ADDR_W'(RESET_ADDR);
            PcAdvance  <= 1'b0;
            FetchErr   <= 1'b0;
        end else begin
            PcAdvance <= capture;
            case (state)
                ST_IDLE: begin
                    if (slot_free && !Flush && !FetchErr) begin
                        state      <= ST_REQ;
                        mem_addr_q <= PcAddr;
                        wait_cnt   <= '0;
                    end
                end
                ST_REQ, ST_DRAIN: begin
                    if (MemAck) begin
                        state <= ST_IDLE;
                    end else if (timed_out) begin
                        state    <= ST_ERR;
                        FetchErr <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (Flush)
                            state <= ST_DRAIN;
                    end
                end
                ST_ERR:  state <= ST_ERR;
                default: state <= ST_IDLE;
            endcase
        end
    end

    fetch_slot #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_slot (
        .Clock     (Clock),
        .Reset     (Reset),
        .capture   (capture),
        .flush     (Flush),
        .ready     (InstrReady),
        .cap_instr (MemData),
        .cap_pc    (mem_addr_q),
        .valid     (InstrValid),
        .instr     (Instr),
        .pc        (InstrPC),
        .free      (slot_free)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            FetchCount <= '0;
            StallCount <= '0;
        end else begin
            if (PcAdvance && (FetchCount != 16'hFFFF))
                FetchCount <= FetchCount + 16'd1;
            if (InstrValid && !InstrReady && (StallCount != 16'hFFFF))
                StallCount <= StallCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch_stage;

    localparam int TIMEOUT = 15;

    logic       Clock;
    logic       Reset;
    logic [7:0] PcAddr;
    logic       PcAdvance;
    logic       MemReq;
    logic [7:0] MemAddr;
    logic       MemAck;
    logic [7:0] MemData;
    logic       Flush;
    logic       InstrValid;
    logic       InstrReady;
    logic [7:0] Instr;
    logic [7:0] InstrPC;
    logic       FetchErr;
`ifdef FETCH_PERF_EN
    logic [15:0] FetchCount;
    logic [15:0] StallCount;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    instr_fetch_stage #(
        .ADDR_W  (8),
        .INSTR_W (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .PcAddr     (PcAddr),
        .PcAdvance  (PcAdvance),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemAck     (MemAck),
        .MemData    (MemData),
        .Flush      (Flush),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .FetchErr   (FetchErr)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (FetchCount),
        .StallCount (StallCount)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (MemReq) break;
            tick();
        end
        check("wait_req", MemReq, 1);
    endtask

    // Reference model: tracks an outstanding fetch as a transaction
    // (busy / dropped / cycles waited) and the decode slot contents.
    bit         m_busy, m_drop, m_valid, m_err, m_adv;
    int         m_wait;
    logic [7:0] m_addr, m_instr, m_pc;
    int         m_fetches, m_stalls;

    initial begin
        forever begin
            @(posedge Clock or posedge Reset);
            if (Reset) begin
                m_busy = 0; m_drop = 0; m_valid = 0; m_err = 0; m_adv = 0;
                m_wait = 0; m_addr = 8'h00; m_instr = 8'h00; m_pc = 8'h00;
                m_fetches = 0; m_stalls = 0;
            end else begin
                bit free_now;
                bit kept;
                free_now = !m_valid || InstrReady;
                kept     = 0;
                if (m_adv && m_fetches < 65535) m_fetches++;
                if (m_valid && !InstrReady && m_stalls < 65535) m_stalls++;
                if (m_busy) begin
                    if (MemAck) begin
                        m_busy = 0;
                        kept   = !m_drop && !Flush;
                    end else if (m_wait + 1 == TIMEOUT) begin
                        m_busy = 0;
                        m_err  = 1;
                    end else begin
                        m_wait++;
                        if (Flush) m_drop = 1;
                    end
                end else if (!m_err && free_now && !Flush) begin
                    m_busy = 1; m_drop = 0; m_wait = 0; m_addr = PcAddr;
                end
                if (Flush) m_valid = 0;
                else if (kept) begin
                    m_valid = 1; m_instr = MemData; m_pc = m_addr;
                end else if (InstrReady) m_valid = 0;
                m_adv = kept;
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                check("cyc_MemReq", MemReq, m_busy);
                check("cyc_MemAddr", MemAddr, m_addr);
                check("cyc_PcAdvance", PcAdvance, m_adv);
                check("cyc_InstrValid", InstrValid, m_valid);
                check("cyc_FetchErr", FetchErr, m_err);
                if (m_valid) begin
                    check("cyc_Instr", Instr, m_instr);
                    check("cyc_InstrPC", InstrPC, m_pc);
                end
`ifdef FETCH_PERF_EN
                check("cyc_FetchCount", FetchCount, m_fetches);
                check("cyc_StallCount", StallCount, m_stalls);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        Reset = 1'b0; PcAddr = 8'h00; MemAck = 1'b0; MemData = 8'h00;
        Flush = 1'b0; InstrReady = 1'b0;
        #1 Reset = 1'b1;
        #1;
        check("rst_MemReq", MemReq, 0);
        check("rst_MemAddr", MemAddr, 0);
        check("rst_PcAdvance", PcAdvance, 0);
        check("rst_InstrValid", InstrValid, 0);
        check("rst_Instr", Instr, 0);
        check("rst_InstrPC", InstrPC, 0);
        check("rst_FetchErr", FetchErr, 0);
        tick(); tick();
        Reset = 1'b0;

        // Basic fetch: ack one cycle after the request appears.
        InstrReady = 1'b1;
        wait_req();
        tick();
        MemAck = 1'b1; MemData = 8'hA5;
        tick();
        check("t1_Instr", Instr, 8'hA5);
        check("t1_InstrPC", InstrPC, 8'h00);
        check("t1_InstrValid", InstrValid, 1);
        check("t1_PcAdvance", PcAdvance, 1);
        check("t1_MemReq", MemReq, 0);
        MemAck = 1'b0; InstrReady = 1'b0; PcAddr = 8'h10;

        // Backpressure: slot full, decode stalled.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_hold_MemReq", MemReq, 0);
            check("t2_hold_PcAdvance", PcAdvance, 0);
        end
        InstrReady = 1'b1;
        tick();
        check("t2_MemReq", MemReq, 1);
        check("t2_MemAddr", MemAddr, 8'h10);
        check("t2_InstrValid", InstrValid, 0);
        InstrReady = 1'b0; MemAck = 1'b1; MemData = 8'h5A;
        tick();
        check("t2_Instr", Instr, 8'h5A);
        check("t2_InstrPC", InstrPC, 8'h10);
        check("t2_PcAdvance", PcAdvance, 1);
        MemAck = 1'b0;

        // Flush two cycles into the request, late ack is drained.
        PcAddr = 8'h20; InstrReady = 1'b1;
        tick();
        check("t3_MemAddr", MemAddr, 8'h20);
        tick();
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("t3_drain_MemReq", MemReq, 1);
        check("t3_drain_InstrValid", InstrValid, 0);
        tick(); tick();
        MemAck = 1'b1; MemData = 8'h3C;
        tick();
        check("t3_InstrValid", InstrValid, 0);
        check("t3_PcAdvance", PcAdvance, 0);
        check("t3_MemReq", MemReq, 0);
        MemAck = 1'b0; PcAddr = 8'h24;
        tick();
        check("t3_next_MemReq", MemReq, 1);
        check("t3_next_MemAddr", MemAddr, 8'h24);
        MemAck = 1'b1; MemData = 8'h77;
        tick();
        check("t3_Instr", Instr, 8'h77);
        check("t3_InstrPC", InstrPC, 8'h24);
        check("t3_PcAdvance", PcAdvance, 1);
        MemAck = 1'b0; PcAddr = 8'h30;

        // Flush and ack in the same cycle.
        tick();
        check("t4_MemAddr", MemAddr, 8'h30);
        Flush = 1'b1; MemAck = 1'b1; MemData = 8'h99;
        tick();
        check("t4_InstrValid", InstrValid, 0);
        check("t4_PcAdvance", PcAdvance, 0);
        check("t4_MemReq", MemReq, 0);
        Flush = 1'b0; MemAck = 1'b0; PcAddr = 8'hFF;
        tick();
        check("t4_ff_MemAddr", MemAddr, 8'hFF);
        MemAck = 1'b1; MemData = 8'hE1; InstrReady = 1'b0;
        tick();
        check("t4_ff_InstrPC", InstrPC, 8'hFF);
        check("t4_ff_Instr", Instr, 8'hE1);
        MemAck = 1'b0;
        Flush = 1'b1;
        tick();
        check("t4_flush_InstrValid", InstrValid, 0);
        check("t4_flush_MemReq", MemReq, 0);
        Flush = 1'b0; PcAddr = 8'h40; InstrReady = 1'b1;

        // Ack timeout.
        tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!MemReq) break;
            cnt++;
            tick();
        end
        check("t5_req_cycles", cnt, TIMEOUT);
        check("t5_FetchErr", FetchErr, 1);
        check("t5_MemReq", MemReq, 0);
        MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        repeat (3) tick();
        check("t5_sticky_FetchErr", FetchErr, 1);
        check("t5_sticky_MemReq", MemReq, 0);
        check("t5_sticky_PcAdvance", PcAdvance, 0);
        #2 Reset = 1'b1;
        #1;
        check("t5_async_FetchErr", FetchErr, 0);
        check("t5_async_MemReq", MemReq, 0);
        #3 Reset = 1'b0;
        tick();

`ifdef FETCH_PERF_EN
        // Five fetches with three backpressure cycles.
        PcAddr = 8'h00; InstrReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_req();
            MemAck = 1'b1; MemData = 8'(i + 1);
            tick();
            MemAck = 1'b0;
            if (i == 1) begin
                InstrReady = 1'b0;
                repeat (3) tick();
                InstrReady = 1'b1;
            end
        end
        tick();
        check("perf_FetchCount", FetchCount, 5);
        check("perf_StallCount", StallCount, 3);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
